// File: rtl/fetch_sequencer.sv
// Layer-level controller for the neuron parameter-fetch datapath: walks the neuron
// descriptors, arms the fetch unit and paces operand fetches. Optional macro: FETCH_SEQ_WATCHDOG_EN.
module fetch_sequencer #(
  parameter int DW         = 16,
  parameter int DESC_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] numNeurons,
  input  logic [DW-1:0] descBase,
  output logic [DW-1:0] descAddr,
  input  logic [DW-1:0] descVal,
  output logic [DW-1:0] numAdds,
  output logic [DW-1:0] offset,
  output logic [DW-1:0] indexOffset,
  output logic [DW-1:0] weightOffset,
  output logic          fetchRst,
  output logic          startFetch,
  input  logic          stall,
  input  logic          fetchWE,
  output logic          neuronDone,
  output logic [DW-1:0] neuronIdx,
  output logic          busy,
  output logic          done
`ifdef FETCH_SEQ_WATCHDOG_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DESC  = 3'd1,
    S_ARM   = 3'd2,
    S_FETCH = 3'd3,
    S_DRAIN = 3'd4,
    S_NEXT  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [DW-1:0] num_neurons_q, num_neurons_d;
  logic [DW-1:0] desc_base_q, desc_base_d;
  logic [DW-1:0] desc_addr_q, desc_addr_d;
  logic [DW-1:0] num_adds_q, num_adds_d;
  logic [DW-1:0] offset_q, offset_d;
  logic [DW-1:0] index_offset_q, index_offset_d;
  logic [DW-1:0] weight_offset_q, weight_offset_d;
  logic [DW-1:0] idx_q, idx_d;
  logic [DW-1:0] remaining_q, remaining_d;
  logic [DW-1:0] we_cnt_q, we_cnt_d;
  logic          busy_q, busy_d;
  logic          start_fetch_s;
  logic [DW-1:0] idx_next_s;
`ifdef FETCH_SEQ_WATCHDOG_EN
  logic [7:0]    drain_cnt_q, drain_cnt_d;
  logic          err_q, err_d;
`endif

  assign idx_next_s = idx_q + DW'(1);

  // Next-state, counter and config-capture logic
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    num_neurons_d   = num_neurons_q;
    desc_base_d     = desc_base_q;
    desc_addr_d     = desc_addr_q;
    num_adds_d      = num_adds_q;
    offset_d        = offset_q;
    index_offset_d  = index_offset_q;
    weight_offset_d = weight_offset_q;
    idx_d           = idx_q;
    remaining_d     = remaining_q;
    busy_d          = busy_q;
    start_fetch_s   = 1'b0;
`ifdef FETCH_SEQ_WATCHDOG_EN
    drain_cnt_d     = 8'd0;
    err_d           = err_q;
`endif

    // Completed operands are counted everywhere except IDLE/ARM, saturating at numAdds
    if (state_q == S_ARM) begin
      we_cnt_d = '0;
    end else if (state_q != S_IDLE && fetchWE && (we_cnt_q < num_adds_q)) begin
      we_cnt_d = we_cnt_q + DW'(1);
    end else begin
      we_cnt_d = we_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (numNeurons != '0) begin
            num_neurons_d = numNeurons;
            desc_base_d   = descBase;
            desc_addr_d   = descBase;
            idx_d         = '0;
            k_d           = 3'd0;
            busy_d        = 1'b1;
            state_d       = S_DESC;
          end else begin
            busy_d  = 1'b0;
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DESC: begin
        // Read data lags the address by one cycle, so word k-1 lands at sub-count k
        case (k_q)
          3'd1:    num_adds_d      = descVal;
          3'd2:    offset_d        = descVal;
          3'd3:    index_offset_d  = descVal;
          3'd4:    weight_offset_d = descVal;
          default: num_adds_d      = num_adds_q;
        endcase
        if (k_q < 3'd3) begin
          desc_addr_d = desc_addr_q + DW'(1);
        end else begin
          desc_addr_d = desc_addr_q;
        end
        if (k_q == 3'd4) begin
          k_d     = 3'd0;
          state_d = S_ARM;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = S_DESC;
        end
      end
      S_ARM: begin
        remaining_d = num_adds_q;
        if (num_adds_q == '0) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if ((remaining_q != '0) && !stall) begin
          start_fetch_s = 1'b1;
          remaining_d   = remaining_q - DW'(1);
          state_d       = (remaining_q == DW'(1)) ? S_DRAIN : S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (we_cnt_q == num_adds_q) begin
          state_d = S_NEXT;
`ifdef FETCH_SEQ_WATCHDOG_EN
        end else if (drain_cnt_q == 8'd16) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
          state_d     = S_DRAIN;
        end
`else
        end else begin
          state_d = S_DRAIN;
        end
`endif
      end
      S_NEXT: begin
        if (idx_q == (num_neurons_q - DW'(1))) begin
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          idx_d       = idx_next_s;
          desc_addr_d = desc_base_q + DW'(DESC_WORDS * idx_next_s);
          k_d         = 3'd0;
          state_d     = S_DESC;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      k_q             <= 3'd0;
      num_neurons_q   <= '0;
      desc_base_q     <= '0;
      desc_addr_q     <= '0;
      num_adds_q      <= '0;
      offset_q        <= '0;
      index_offset_q  <= '0;
      weight_offset_q <= '0;
      idx_q           <= '0;
      remaining_q     <= '0;
      we_cnt_q        <= '0;
      busy_q          <= 1'b0;
`ifdef FETCH_SEQ_WATCHDOG_EN
      drain_cnt_q     <= 8'd0;
      err_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      num_neurons_q   <= num_neurons_d;
      desc_base_q     <= desc_base_d;
      desc_addr_q     <= desc_addr_d;
      num_adds_q      <= num_adds_d;
      offset_q        <= offset_d;
      index_offset_q  <= index_offset_d;
      weight_offset_q <= weight_offset_d;
      idx_q           <= idx_d;
      remaining_q     <= remaining_d;
      we_cnt_q        <= we_cnt_d;
      busy_q          <= busy_d;
`ifdef FETCH_SEQ_WATCHDOG_EN
      drain_cnt_q     <= drain_cnt_d;
      err_q           <= err_d;
`endif
    end
  end

  assign descAddr     = desc_addr_q;
  assign numAdds      = num_adds_q;
  assign offset       = offset_q;
  assign indexOffset  = index_offset_q;
  assign weightOffset = weight_offset_q;
  assign neuronIdx    = idx_q;
  assign busy         = busy_q;
  assign startFetch   = start_fetch_s;
  assign fetchRst     = (state_q == S_ARM);
  assign neuronDone   = (state_q == S_NEXT);
  assign done         = (state_q == S_FIN);
`ifdef FETCH_SEQ_WATCHDOG_EN
  assign err          = err_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: descriptor memory and 3-cycle fetch-unit models,
// expected per-neuron records queued at stimulus time and checked by a separate monitor.
module tb_fetch_sequencer;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          fetchWE;
  logic [DW-1:0] numNeurons = '0;
  logic [DW-1:0] descBase = '0;
  logic [DW-1:0] descVal = '0;
  logic [DW-1:0] descAddr, numAdds, offset, indexOffset, weightOffset, neuronIdx;
  logic          fetchRst, startFetch, neuronDone, busy, done;
`ifdef FETCH_SEQ_WATCHDOG_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.DW(DW), .DESC_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .numNeurons(numNeurons), .descBase(descBase),
    .descAddr(descAddr), .descVal(descVal), .numAdds(numAdds), .offset(offset),
    .indexOffset(indexOffset), .weightOffset(weightOffset), .fetchRst(fetchRst),
    .startFetch(startFetch), .stall(stall), .fetchWE(fetchWE), .neuronDone(neuronDone),
    .neuronIdx(neuronIdx), .busy(busy), .done(done)
`ifdef FETCH_SEQ_WATCHDOG_EN
    , .err(err)
`endif
  );

  // Synchronous-read descriptor memory
  logic [15:0] mem [65536];
  always @(posedge clk) descVal <= mem[descAddr];

  // Fetch unit: WE three cycles after each startFetch, optionally dropping one
  logic [2:0] pipe = 3'd0;
  logic       we_q = 1'b0;
  int         drop_req = 0;
  int         dropped = 0;
  always @(posedge clk) begin
    pipe <= {pipe[1:0], startFetch};
    if (pipe[1] && (drop_req > dropped)) begin
      we_q    <= 1'b0;
      dropped <= dropped + 1;
    end else begin
      we_q <= pipe[1];
    end
  end
  assign fetchWE = we_q;

  typedef struct {
    logic [15:0] idx, na, off, ioff, woff;
    int          we;
  } rec_t;
  rec_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int sf_cnt = 0, we_cnt = 0, rst_cnt = 0, done_cnt = 0, nd_cnt = 0;
  int fcyc = 0, stall_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT events against the queued expectations
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      fcyc = fetchRst ? 0 : fcyc + 1;
      if (rst) begin
        if (startFetch) begin
          sf_cnt++;
          chk("startFetch_while_stalled", int'(stall), 0);
        end
        if (fetchWE) we_cnt++;
        if (fetchRst) begin
          rst_cnt++;
          sf_cnt = 0;
          we_cnt = 0;
          chk("fetchRst_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            chk("cfg_numAdds", int'(numAdds), int'(exp_q[0].na));
            chk("cfg_offset", int'(offset), int'(exp_q[0].off));
            chk("cfg_indexOffset", int'(indexOffset), int'(exp_q[0].ioff));
            chk("cfg_weightOffset", int'(weightOffset), int'(exp_q[0].woff));
          end
        end
        if (neuronDone) begin
          nd_cnt++;
          chk("neuronDone_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("neuronIdx", int'(neuronIdx), int'(r.idx));
            chk("startFetch_count", sf_cnt, int'(r.na));
            chk("fetchWE_count", we_cnt, r.we);
            chk("busy_in_layer", int'(busy), 1);
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_at_done", int'(busy), 0);
          chk("neurons_left_at_done", exp_q.size(), 0);
        end
      end
    end
  end

  // Stall driver: window mode stalls FETCH cycles 2..5, random mode stalls ~25%
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       stall = (fcyc >= 1) && (fcyc <= 4);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
    end
  end

  task automatic set_desc(input logic [15:0] base, input int i, input logic [15:0] na,
                          input logic [15:0] off, input logic [15:0] ioff, input logic [15:0] woff);
    logic [15:0] a;
    a = base + 16'(4 * i);
    mem[a] = na;   a = a + 16'd1;
    mem[a] = off;  a = a + 16'd1;
    mem[a] = ioff; a = a + 16'd1;
    mem[a] = woff;
  endtask

  task automatic push_exp(input logic [15:0] base, input int n, input bit drop_first);
    rec_t        r;
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a      = base + 16'(4 * i);
      r.idx  = 16'(i);
      r.na   = mem[a]; a = a + 16'd1;
      r.off  = mem[a]; a = a + 16'd1;
      r.ioff = mem[a]; a = a + 16'd1;
      r.woff = mem[a];
      r.we   = int'(r.na);
      if (drop_first && i == 0 && r.we > 0) r.we = r.we - 1;
      exp_q.push_back(r);
    end
  endtask

  task automatic pulse_start(input logic [15:0] nn, input logic [15:0] base);
    @(posedge clk); #1;
    start = 1'b1; numNeurons = nn; descBase = base;
    @(posedge clk); #1;
    start = 1'b0; numNeurons = 16'($urandom); descBase = 16'($urandom);
  endtask

  task automatic run_layer(input logic [15:0] nn, input logic [15:0] base,
                           input bit poke, input bit drop_first, output int cycles);
    int d0;
    push_exp(base, int'(nn), drop_first);
    d0 = done_cnt;
    pulse_start(nn, base);
    cycles = 0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      chk("busy_during_layer", int'(busy), 1);
      start = 1'b1; numNeurons = 16'd7; descBase = 16'h1234;
      @(posedge clk); #1;
      start = 1'b0;
      cycles = 3;
    end
    while (done_cnt == d0 && cycles < 3000) begin
      @(posedge clk);
      cycles++;
    end
    chk("layer_done_seen", int'(done_cnt != d0), 1);
    @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("busy_after_layer", int'(busy), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_descAddr"}, int'(descAddr), 0);
    chk({tag, "_numAdds"}, int'(numAdds), 0);
    chk({tag, "_offset"}, int'(offset), 0);
    chk({tag, "_indexOffset"}, int'(indexOffset), 0);
    chk({tag, "_weightOffset"}, int'(weightOffset), 0);
    chk({tag, "_neuronIdx"}, int'(neuronIdx), 0);
    chk({tag, "_pulses"}, int'({busy, done, fetchRst, startFetch, neuronDone}), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
  endtask

  initial begin
    int cyc, r0, d0, n0, nn;
    logic [15:0] base;
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
`ifdef FETCH_SEQ_WATCHDOG_EN
    chk("reset_err", int'(err), 0);
`endif
    @(posedge clk); #1; rst = 1'b1;

    // Basic single neuron
    set_desc(16'h0010, 0, 16'd3, 16'h0100, 16'h0200, 16'h0300);
    run_layer(16'd1, 16'h0010, 1'b0, 1'b0, cyc);

    // Three neurons with descriptor addresses wrapping past 0xFFFF
    set_desc(16'hFFFC, 0, 16'd2, 16'hA001, 16'hA002, 16'hA003);
    set_desc(16'hFFFC, 1, 16'd1, 16'hB001, 16'hB002, 16'hB003);
    set_desc(16'hFFFC, 2, 16'd3, 16'hC001, 16'hC002, 16'hC003);
    run_layer(16'd3, 16'hFFFC, 1'b1, 1'b0, cyc);

    // Stall window inside FETCH
    stall_mode = 1;
    set_desc(16'h0040, 0, 16'd4, 16'h0111, 16'h0222, 16'h0333);
    run_layer(16'd1, 16'h0040, 1'b0, 1'b0, cyc);
    stall_mode = 0;

    // Empty layer: done the cycle after start, no fetch-unit load
    r0 = rst_cnt;
    run_layer(16'd0, 16'h0050, 1'b0, 1'b0, cyc);
    chk("zero_layer_latency", cyc, 1);
    chk("zero_layer_no_fetchRst", rst_cnt - r0, 0);

    // Neuron with no operands
    set_desc(16'h0060, 0, 16'd0, 16'h0ABC, 16'h0DEF, 16'h0123);
    run_layer(16'd1, 16'h0060, 1'b0, 1'b0, cyc);

    // Reset in the middle of FETCH, then a clean rerun
    set_desc(16'h0070, 0, 16'd5, 16'h0555, 16'h0666, 16'h0777);
    push_exp(16'h0070, 1, 1'b0);
    pulse_start(16'd1, 16'h0070);
    cyc = 0;
    while (sf_cnt < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("midfetch_reached", int'(sf_cnt >= 2), 1);
    do_reset();
    @(negedge clk);
    check_idle("midfetch_reset");
    exp_q.delete();
    repeat (6) @(posedge clk);
    run_layer(16'd1, 16'h0070, 1'b0, 1'b0, cyc);

    // Maximum neuron count: run ten neurons, confirm no premature done, then abort
    push_exp(16'h8000, 12, 1'b0);
    d0 = done_cnt;
    n0 = nd_cnt;
    pulse_start(16'hFFFF, 16'h8000);
    cyc = 0;
    while ((nd_cnt - n0) < 10 && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    chk("max_layer_progress", nd_cnt - n0, 10);
    chk("max_layer_no_done", done_cnt - d0, 0);
    do_reset();
    exp_q.delete();
    repeat (6) @(posedge clk);

    // Randomized layers with random stall
    stall_mode = 2;
    for (int t = 0; t < 8; t++) begin
      nn   = $urandom_range(1, 4);
      base = 16'($urandom);
      for (int i = 0; i < nn; i++)
        set_desc(base, i, 16'($urandom_range(0, 6)), 16'($urandom), 16'($urandom), 16'($urandom));
      run_layer(16'(nn), base, t[0], 1'b0, cyc);
    end
    stall_mode = 0;

`ifdef FETCH_SEQ_WATCHDOG_EN
    // One dropped WE: watchdog ends DRAIN, flags err, layer still completes
    chk("wd_err_before", int'(err), 0);
    set_desc(16'h4000, 0, 16'd3, 16'h0E01, 16'h0E02, 16'h0E03);
    set_desc(16'h4000, 1, 16'd2, 16'h0F01, 16'h0F02, 16'h0F03);
    drop_req = dropped + 1;
    run_layer(16'd2, 16'h4000, 1'b0, 1'b1, cyc);
    chk("wd_err_set", int'(err), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("wd_err_sticky", int'(err), 1);
    do_reset();
    @(negedge clk);
    chk("wd_err_cleared", int'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
